// File: rtl/lcd_if.sv
// lcd_if: LSU-to-LCD-controller request handshake with busy flag
interface lcd_if;
  logic        req_valid;
  logic [31:0] req_data;
  logic        req_ready;
  logic        busy;
  modport master (output req_valid, req_data, input req_ready, busy);
  modport slave  (input req_valid, req_data, output req_ready, busy);
endinterface

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 bus-cycle sequencer with busy flag; define LCD_INIT_EN for the built-in power-on init sequence
module lcd_ctrl #(
  parameter int SETUP_CYC  = 2,
  parameter int EN_CYC     = 12,
  parameter int HOLD_CYC   = 2,
  parameter int WAIT_SHORT = 2000,
  parameter int WAIT_LONG  = 82000,
  parameter int INIT_DLY   = 750000
) (
  input  logic       clk,
  input  logic       rst,
  lcd_if.slave       bus,
  output logic       LCD_ON,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic [7:0] LCD_DATA
);
`ifdef LCD_INIT_EN
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, PWRUP} state_t;
  localparam state_t RST_ST = PWRUP;
  localparam logic [19:0] RST_CNT = 20'(INIT_DLY - 1);
`else
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
  localparam state_t RST_ST = IDLE;
  localparam logic [19:0] RST_CNT = 20'd0;
`endif
  state_t      state, state_nx;
  logic [19:0] cnt, cnt_nx;
  logic        ld, rs_nx, on_nx;
  logic [7:0]  data_nx;
  logic        done, long_cmd;
  logic        unused_bits;
`ifdef LCD_INIT_EN
  logic [1:0]  idx, idx_nx, idx_inc;
  logic        ini, ini_nx;
  logic [7:0]  init_cmd;
  assign idx_inc  = idx + 2'd1;
  assign init_cmd = idx_inc == 2'd1 ? 8'h0C : idx_inc == 2'd2 ? 8'h01 : 8'h06;
`endif
  assign unused_bits   = ^bus.req_data[30:9];
  assign done          = cnt == 20'd0;
  assign long_cmd      = !LCD_RS && LCD_DATA[7:2] == 6'd0 && LCD_DATA[1:0] != 2'd0;
  assign bus.req_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign LCD_EN        = state == PULSE;
  assign LCD_RW        = 1'b0;
  // State, countdown and the pin shadow registers; reset clears pins asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= RST_ST;
      cnt      <= RST_CNT;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
      LCD_ON   <= 1'b0;
`ifdef LCD_INIT_EN
      idx      <= 2'd0;
      ini      <= 1'b1;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ld) begin
        LCD_RS   <= rs_nx;
        LCD_DATA <= data_nx;
        LCD_ON   <= on_nx;
      end
`ifdef LCD_INIT_EN
      idx <= idx_nx;
      ini <= ini_nx;
`endif
    end
  // Next state, counter reload on every state entry, and pin load on acceptance
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - 20'd1;
    ld       = 1'b0;
    rs_nx    = bus.req_data[8];
    data_nx  = bus.req_data[7:0];
    on_nx    = bus.req_data[31];
`ifdef LCD_INIT_EN
    idx_nx   = idx;
    ini_nx   = ini;
`endif
    case (state)
      IDLE: if (bus.req_valid) begin
        ld       = 1'b1;
        state_nx = SETUP;
        cnt_nx   = 20'(SETUP_CYC - 1);
      end
      SETUP: if (done) begin
        state_nx = PULSE;
        cnt_nx   = 20'(EN_CYC - 1);
      end
      PULSE: if (done) begin
        state_nx = HOLD;
        cnt_nx   = 20'(HOLD_CYC - 1);
      end
      HOLD: if (done) begin
        state_nx = WAIT;
        cnt_nx   = long_cmd ? 20'(WAIT_LONG - 1) : 20'(WAIT_SHORT - 1);
      end
      WAIT: if (done) begin
        state_nx = IDLE;
        cnt_nx   = 20'd0;
`ifdef LCD_INIT_EN
        if (ini && idx != 2'd3) begin
          ld       = 1'b1;
          rs_nx    = 1'b0;
          data_nx  = init_cmd;
          on_nx    = 1'b1;
          idx_nx   = idx_inc;
          state_nx = SETUP;
          cnt_nx   = 20'(SETUP_CYC - 1);
        end else
          ini_nx = 1'b0;
`endif
      end
`ifdef LCD_INIT_EN
      PWRUP: if (done) begin
        ld       = 1'b1;
        rs_nx    = 1'b0;
        data_nx  = 8'h38;
        on_nx    = 1'b1;
        state_nx = SETUP;
        cnt_nx   = 20'(SETUP_CYC - 1);
      end
`endif
      default: state_nx = RST_ST;
    endcase
  end
endmodule
